// File: rtl/imem_uart_loader_pkg.sv
// Shared encodings for the UART program loader.
package imem_uart_loader_pkg;

    // 100 MHz system clock, 115200 baud
    localparam int unsigned ClksPerBitDefault = 868;

    typedef enum logic [2:0] {
        StHdr0,
        StHdr1,
        StData,
        StDone,
        StErr
    } ld_state_e;

    typedef enum logic [1:0] {
        RxIdle,
        RxStart,
        RxData,
        RxStop
    } rx_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: synchroniser, bit timing, one-cycle byte/frame-error strobes.
module uart_rx_byte
    import imem_uart_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = ClksPerBitDefault
) (
    input  logic       w_clk,
    input  logic       w_rst,
    input  logic       w_rxd,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] CntFull = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    rx_state_e       state_q, state_d;
    logic            sync1_q, sync2_q, prev_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;

    // State register plus synchroniser; line flops reset to idle-high
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= RxIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            sync1_q <= w_rxd;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    // Next-state: bit-timing counter and LSB-first shift register
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CntOne;
        bit_d   = bit_q;
        shift_d = shift_q;
        unique case (state_q)
            RxIdle: begin
                cnt_d = '0;
                if (prev_q && !sync2_q) state_d = RxStart;
            end
            RxStart: begin
                if (cnt_q == CntHalf) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    // Line back high at mid start bit means a glitch
                    state_d = sync2_q ? RxIdle : RxData;
                end
            end
            RxData: begin
                if (cnt_q == CntFull) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = RxStop;
                end
            end
            RxStop: begin
                if (cnt_q == CntFull) begin
                    cnt_d   = '0;
                    state_d = RxIdle;
                end
            end
            default: state_d = RxIdle;
        endcase
    end

    // Outputs: strobes on the stop-bit sample
    always_comb begin
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        rx_byte    = shift_q;
        if (state_q == RxStop && cnt_q == CntFull) begin
            byte_valid = sync2_q;
            frame_err  = !sync2_q;
        end
    end

endmodule

// File: rtl/imem_uart_loader.sv
// Loads a program image from UART into imem, then releases the CPU clock-enable.
module imem_uart_loader
    import imem_uart_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = ClksPerBitDefault,
    parameter int unsigned ADDR_W       = 12,
    parameter int unsigned MAX_WORDS    = 4096
) (
    input  logic              w_clk,
    input  logic              w_rst,
    input  logic              w_rxd,
    output logic              w_we,
    output logic [ADDR_W-1:0] w_addr,
    output logic [31:0]       w_wdata,
    output logic              w_ce,
    output logic              w_err
);

    localparam logic [ADDR_W:0] IdxOne = (ADDR_W + 1)'(1);

    logic [7:0] rx_byte;
    logic       byte_valid;
    logic       frame_err;

    ld_state_e         state_q, state_d;
    logic [15:0]       n_q, n_d, n_new;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [1:0]        lane_q, lane_d;
    logic [23:0]       asm_q, asm_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              ce_q, ce_d;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .w_clk     (w_clk),
        .w_rst     (w_rst),
        .w_rxd     (w_rxd),
        .rx_byte   (rx_byte),
        .byte_valid(byte_valid),
        .frame_err (frame_err)
    );

    // State register and write-port registers
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            state_q <= StHdr0;
            n_q     <= '0;
            idx_q   <= '0;
            lane_q  <= '0;
            asm_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ce_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            lane_q  <= lane_d;
            asm_q   <= asm_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ce_q    <= ce_d;
        end
    end

    // Next-state: header decode, byte-lane assembly, word write
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        idx_d   = idx_q;
        lane_d  = lane_q;
        asm_d   = asm_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ce_d    = (state_q == StDone);
        n_new   = {rx_byte, n_q[7:0]};
        unique case (state_q)
            StHdr0: begin
                if (frame_err) begin
                    state_d = StErr;
                end else if (byte_valid) begin
                    n_d     = {8'h00, rx_byte};
                    state_d = StHdr1;
                end
            end
            StHdr1: begin
                if (frame_err) begin
                    state_d = StErr;
                end else if (byte_valid) begin
                    n_d    = n_new;
                    idx_d  = '0;
                    lane_d = '0;
                    if (n_new == 16'd0)                state_d = StDone;
                    else if (32'(n_new) > MAX_WORDS)   state_d = StErr;
                    else                               state_d = StData;
                end
            end
            StData: begin
                if (frame_err) begin
                    state_d = StErr;
                end else begin
                    // Finish on the cycle after the last write pulse
                    if (we_q && 32'(idx_q) == 32'(n_q)) state_d = StDone;
                    if (byte_valid) begin
                        if (lane_q == 2'd3) begin
                            we_d    = 1'b1;
                            addr_d  = idx_q[ADDR_W-1:0];
                            wdata_d = {rx_byte, asm_q};
                            idx_d   = idx_q + IdxOne;
                            lane_d  = 2'd0;
                        end else begin
                            asm_d[{lane_q, 3'b000} +: 8] = rx_byte;
                            lane_d = lane_q + 2'd1;
                        end
                    end
                end
            end
            StDone:  ;
            StErr:   ;
            default: state_d = StHdr0;
        endcase
    end

    // Outputs: write port holds last values; only w_we qualifies them
    always_comb begin
        w_we    = we_q;
        w_addr  = addr_q;
        w_wdata = wdata_q;
        w_ce    = ce_q;
        w_err   = (state_q == StErr);
    end

endmodule
